// File: rtl/mux4_arbiter.sv
// Round-robin arbiter for four requesters sharing a registered 4:1 data path.
// Optional grant watchdog enabled by defining MUX4_ARBITER_WATCHDOG_EN.
module mux4_arbiter (
    input  logic       clock,
    input  logic       reset_n,
    input  logic [3:0] req,
    input  logic       D0,
    input  logic       D1,
    input  logic       D2,
    input  logic       D3,
    output logic [3:0] gnt,
    output logic [1:0] S,
    output logic       busy,
    output logic       Y
);

    typedef enum logic [0:0] {StIdle, StGrant} state_e;

    state_e     state_q, state_d;
    logic [1:0] s_q, s_d;
    logic [1:0] ptr_q, ptr_d;
    logic       y_q, y_d;
    logic [3:0] d_vec;
    logic       pick_valid;
    logic [1:0] pick_idx;
    logic [1:0] cand;
    logic       wd_expire;
    logic       grant_end;

    assign d_vec = {D3, D2, D1, D0};

    // Scan from ptr upward; iterate farthest offset first so the nearest hit wins.
    always_comb begin
        pick_valid = 1'b0;
        pick_idx   = ptr_q;
        cand       = 2'd0;
        for (int k = 3; k >= 0; k--) begin
            cand = ptr_q + 2'(k);
            if (req[cand]) begin
                pick_valid = 1'b1;
                pick_idx   = cand;
            end
        end
    end

`ifdef MUX4_ARBITER_WATCHDOG_EN
    logic [2:0] wd_cnt_q, wd_cnt_d;

    assign wd_expire = (state_q == StGrant) && (wd_cnt_q == 3'd7);

    // Counts completed grant cycles; cleared whenever the grant is not continuing.
    always_comb begin
        wd_cnt_d = 3'd0;
        if (state_q == StGrant && !grant_end) begin
            wd_cnt_d = wd_cnt_q + 3'd1;
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            wd_cnt_q <= 3'd0;
        end else begin
            wd_cnt_q <= wd_cnt_d;
        end
    end
`else
    assign wd_expire = 1'b0;
`endif

    assign grant_end = !req[s_q] || wd_expire;

    // State register
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= StIdle;
            s_q     <= 2'd0;
            ptr_q   <= 2'd0;
            y_q     <= 1'b0;
        end else begin
            state_q <= state_d;
            s_q     <= s_d;
            ptr_q   <= ptr_d;
            y_q     <= y_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        s_d     = s_q;
        ptr_d   = ptr_q;
        y_d     = (state_q == StGrant) ? d_vec[s_q] : 1'b0;
        unique case (state_q)
            StIdle: begin
                if (pick_valid) begin
                    state_d = StGrant;
                    s_d     = pick_idx;
                end
            end
            StGrant: begin
                if (grant_end) begin
                    state_d = StIdle;
                    ptr_d   = s_q + 2'd1;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    // Outputs: grant decoded from the registered select, so it is one-hot by construction.
    always_comb begin
        gnt  = 4'b0000;
        busy = (state_q == StGrant);
        if (busy) begin
            gnt[s_q] = 1'b1;
        end
        S = s_q;
        Y = y_q;
    end

endmodule

// File: tb/tb_mux4_arbiter.sv
// Self-checking bench for mux4_arbiter: directed scenarios plus randomized traffic
// compared every cycle against a behavioural round-robin model.
module tb_mux4_arbiter;

`ifdef MUX4_ARBITER_WATCHDOG_EN
    localparam bit Wd = 1'b1;
`else
    localparam bit Wd = 1'b0;
`endif

    logic       clock = 1'b0;
    logic       reset_n;
    logic [3:0] req;
    logic       D0, D1, D2, D3;
    logic [3:0] gnt;
    logic [1:0] S;
    logic       busy;
    logic       Y;

    int checks = 0;
    int failures = 0;

    mux4_arbiter dut (
        .clock  (clock),
        .reset_n(reset_n),
        .req    (req),
        .D0     (D0),
        .D1     (D1),
        .D2     (D2),
        .D3     (D3),
        .gnt    (gnt),
        .S      (S),
        .busy   (busy),
        .Y      (Y)
    );

    always #5 clock = ~clock;

    // Behavioural model: owner index, grant length so far, next-scan pointer.
    bit m_busy;
    int m_s, m_ptr, m_len;
    bit m_y;
    logic [3:0] dv;
    assign dv = {D3, D2, D1, D0};

    function automatic int first_req(logic [3:0] r, int p);
        for (int k = 0; k < 4; k++) begin
            if (r[(p + k) % 4]) return (p + k) % 4;
        end
        return 0;
    endfunction

    always @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            m_busy <= 1'b0;
            m_s    <= 0;
            m_ptr  <= 0;
            m_len  <= 0;
            m_y    <= 1'b0;
        end else begin
            m_y <= m_busy ? dv[m_s] : 1'b0;
            if (!m_busy) begin
                if (req != 4'b0000) begin
                    m_busy <= 1'b1;
                    m_s    <= first_req(req, m_ptr);
                    m_len  <= 1;
                end
            end else if (!req[m_s] || (Wd && m_len == 8)) begin
                m_busy <= 1'b0;
                m_ptr  <= (m_s + 1) % 4;
            end else begin
                m_len <= m_len + 1;
            end
        end
    end

    task automatic chk(input string name, input logic [3:0] act, input logic [3:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    always @(negedge clock) begin
        if (reset_n) begin
            chk("model_gnt", gnt, m_busy ? (4'b0001 << m_s) : 4'b0000);
            chk("model_S", {2'b00, S}, 4'(m_s));
            chk("model_busy", {3'b000, busy}, {3'b000, m_busy});
            chk("model_Y", {3'b000, Y}, {3'b000, m_y});
            chk("onehot", 4'($countones(gnt) <= 1), 4'd1);
        end
    end

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic set_d(input logic [3:0] v);
        {D3, D2, D1, D0} = v;
    endtask

    logic [3:0] exp_g;

    initial begin
        reset_n = 1'b0;
        req     = 4'b0000;
        set_d(4'b0000);
        #3;
        chk("rst_gnt", gnt, 4'b0000);
        chk("rst_S", {2'b00, S}, 4'd0);
        chk("rst_busy", {3'b000, busy}, 4'd0);
        chk("rst_Y", {3'b000, Y}, 4'd0);
        #9 reset_n = 1'b1;

        // Single request to 2 with data latency
        req = 4'b0100;
        set_d(4'b0100);
        tick();
        chk("d1_gnt", gnt, 4'b0100);
        chk("d1_S", {2'b00, S}, 4'd2);
        chk("d1_busy", {3'b000, busy}, 4'd1);
        tick();
        chk("d1_Y", {3'b000, Y}, 4'd1);
        req = 4'b0000;
        tick();
        chk("d1_release", {3'b000, busy}, 4'd0);

        reset_n = 1'b0;
        #1 reset_n = 1'b1;

        // All requesting, each drops after two grant cycles
        for (int g = 0; g < 5; g++) begin
            req = 4'b1111;
            tick();
            chk("rr_gnt_a", gnt, 4'b0001 << (g % 4));
            tick();
            chk("rr_gnt_b", gnt, 4'b0001 << (g % 4));
            req[g % 4] = 1'b0;
            tick();
            chk("rr_idle", gnt, 4'b0000);
        end

        // Handover in the same cycle: 1 releases, 3 raises
        req = 4'b0010;
        tick();
        chk("ho_gnt1", gnt, 4'b0010);
        req = 4'b1000;
        tick();
        chk("ho_idle", gnt, 4'b0000);
        tick();
        chk("ho_gnt3", gnt, 4'b1000);
        chk("ho_S3", {2'b00, S}, 4'd3);

        // Reset mid-grant
        req = 4'b0000;
        tick();
        req = 4'b0100;
        set_d(4'b0100);
        tick();
        chk("mr_gnt2", gnt, 4'b0100);
        tick();
        chk("mr_Y", {3'b000, Y}, 4'd1);
        #2 reset_n = 1'b0;
        #1;
        chk("mr_gnt0", gnt, 4'b0000);
        chk("mr_busy0", {3'b000, busy}, 4'd0);
        chk("mr_S0", {2'b00, S}, 4'd0);
        chk("mr_Y0", {3'b000, Y}, 4'd0);
        req = 4'b0110;
        reset_n = 1'b1;
        tick();
        chk("mr_after", gnt, 4'b0010);

        // Long hold: watchdog rotation or indefinite grant
        reset_n = 1'b0;
        #1 reset_n = 1'b1;
        req = 4'b0011;
        for (int c = 0; c < 20; c++) begin
            tick();
            if (Wd) begin
                if (c % 18 < 8) exp_g = 4'b0001;
                else if (c % 18 == 8 || c % 18 == 17) exp_g = 4'b0000;
                else exp_g = 4'b0010;
            end else begin
                exp_g = 4'b0001;
            end
            chk("hold_gnt", gnt, exp_g);
        end

        // Randomized traffic
        req = 4'b0000;
        for (int n = 0; n < 3000; n++) begin
            tick();
            for (int i = 0; i < 4; i++) begin
                if ($urandom_range(0, 5) == 0) req[i] = ~req[i];
            end
            set_d(4'($urandom_range(0, 15)));
            if ($urandom_range(0, 299) == 0) begin
                reset_n = 1'b0;
                #2 reset_n = 1'b1;
            end
        end

        tick();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/mux4_arbiter.md
MUX4_ARBITER -- requirements
Module: mux4_arbiter

Interface
REQ-001 SHALL have port clock, input, 1 bit: single system clock; all state updates on its rising edge.
REQ-002 SHALL have port reset_n, input, 1 bit: asynchronous, active-low reset.
REQ-003 SHALL have port req, input, 4 bits: req[i] high means requester i wants the shared 4:1 data path; held high for the whole transfer.
REQ-004 SHALL have ports D0, D1, D2, D3, input, 1 bit each: requester data bits.
REQ-005 SHALL have port gnt, output, 4 bits: one-hot grant, or all zero.
REQ-006 SHALL have port S, output, 2 bits: registered select, equal to the index of the granted requester.
REQ-007 SHALL have port busy, output, 1 bit: high while any grant is active.
REQ-008 SHALL have port Y, output, 1 bit: registered mux output.

Function
REQ-009 SHALL implement two states.
- IDLE: gnt=0, busy=0.
- GRANT: exactly one gnt bit high, busy=1.
REQ-010 In IDLE with req≠0, the block SHALL move to GRANT at the next edge, granting the first requester with req set, scanning from ptr upward, mod 4 (round-robin).
REQ-011 The grant decision and the S update SHALL take effect in the same edge, so S always equals the index of the high gnt bit.
REQ-012 In GRANT, the block SHALL hold gnt and S unchanged while req[S]=1, whatever the other req bits do.
REQ-013 In GRANT, when req[S]=0 is sampled, the block SHALL clear gnt and busy, set ptr=S+1 mod 4, and return to IDLE at that edge.
- This gives one mandatory idle cycle between grants.
REQ-014 In IDLE with req=0, the block SHALL hold S at its last value and leave ptr unchanged.
REQ-015 Y SHALL register D[S] every cycle busy=1 and register 0 every cycle busy=0.
- Data latency: one cycle from D sampled to Y.
REQ-016 A request raised during the same cycle another request is released SHALL be arbitrated in the following IDLE cycle, using the updated ptr.
REQ-017 A single requester holding req continuously SHALL keep its grant indefinitely, unless the watchdog (REQ-022) is compiled in.
REQ-018 gnt SHALL never have more than one bit set, in any cycle.

Reset
REQ-019 On reset_n low, the block SHALL immediately (asynchronously) force: state=IDLE, gnt=4'b0000, busy=0, S=2'b00, Y=0, ptr=0, watchdog count=0.
REQ-020 A reset asserted mid-grant SHALL abort the grant with no completion cycle.
REQ-021 After reset_n rises, the first arbitration SHALL use priority order 0,1,2,3.

Configuration
REQ-022 With macro MUX4_ARBITER_WATCHDOG_EN defined:
- A 3-bit counter SHALL count cycles in GRANT.
- On the 8th consecutive GRANT cycle, the grant SHALL be forcibly released exactly as in REQ-013, even though req[S]=1.
- The requester re-competes from IDLE with ptr advanced past it.
REQ-023 Without MUX4_ARBITER_WATCHDOG_EN, the counter SHALL be absent and grants SHALL end only through REQ-013.

Verification
REQ-024 Reset, then req=4'b0100 -> next edge: gnt=4'b0100, S=2, busy=1; with D2=1, Y=1 one cycle later.
REQ-025 req=4'b1111 held continuously, each granted requester drops req after 2 grant cycles -> grant order 0,1,2,3,0, with one idle cycle between grants.
REQ-026 Grant to 1 active, req[3] raised and req[1] dropped in the same cycle -> IDLE one cycle, then gnt=4'b1000, S=3.
REQ-027 reset_n pulsed low mid-grant to 2 -> gnt=0, busy=0, S=0, Y=0 immediately; after release with req=4'b0110, grant goes to 1.
REQ-028 MUX4_ARBITER_WATCHDOG_EN defined, req=4'b0011 held forever -> requester 0 granted for 8 cycles, IDLE 1 cycle, requester 1 granted for 8 cycles, then back to 0.
- Without the macro: requester 0 keeps the grant indefinitely.
